// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Program counter and fetch stage in front of the program ROM.
//            Drives the ROM address/enable, captures the combinational
//            opcode/operand into an instruction register, and offers it
//            downstream over a valid/ready handshake. Accepts redirects
//            from execute plus start/halt control.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            start, halt_req            - run control
//            redirect_valid/_pc         - control-flow redirect (flushes)
//            rom_addr, rom_enable       - ROM request (rom_addr == PC)
//            rom_opcode, rom_operand    - ROM response (combinational)
//            instr_valid/_ready         - downstream handshake
//            instr_opcode/_operand/_pc  - captured instruction
//            halted                     - FSM is in HALTED
// Config   : FETCH_HALT_DETECT_EN - when defined, fetching HALT_OPCODE
//            presents it and then stops in HALTED with PC on that address.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter int                      DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0]   RESET_PC    = 16'h0000,
  parameter logic [DATA_WIDTH-1:0]   HALT_OPCODE = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] rom_addr,
  output logic                  rom_enable,
  input  logic [DATA_WIDTH-1:0] rom_opcode,
  input  logic [DATA_WIDTH-1:0] rom_operand,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_opcode,
  output logic [DATA_WIDTH-1:0] instr_operand,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  halted
);

`ifdef FETCH_HALT_DETECT_EN
  localparam bit c_halt_detect = 1'b1;
`else
  localparam bit c_halt_detect = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_opcode;
  logic [DATA_WIDTH-1:0] r_operand;
  logic [DATA_WIDTH-1:0] r_instr_pc;

  logic                  w_fetch;
  logic                  w_halt_hit;

  // A fetch needs the ROM enabled (RUN), no stop/redirect this cycle, and
  // room in the instruction register (empty or being consumed now).
  assign w_fetch = (r_state == S_RUN) && !halt_req && !redirect_valid &&
                   (!r_valid || instr_ready);

  // Self-halt: the halt opcode is still presented, but fetching stops on it.
  assign w_halt_hit = c_halt_detect && w_fetch && (rom_opcode == HALT_OPCODE);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. A redirect does not block a simultaneous halt_req or
  // start; both the redirect and the state change take effect.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (halt_req || w_halt_hit) begin
          w_state_next = S_HALTED;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Program counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (w_fetch && !w_halt_hit) begin
      r_pc <= r_pc + DATA_WIDTH'(1);  // wraps modulo 2^DATA_WIDTH
    end
  end

  // --------------------------------------------------------------------------
  // Instruction register and valid flag. Redirect flushes regardless of
  // instr_ready; instr_* contents are simply left as they were.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_opcode   <= '0;
      r_operand  <= '0;
      r_instr_pc <= '0;
    end else if (redirect_valid) begin
      r_valid <= 1'b0;
    end else if (w_fetch) begin
      r_valid    <= 1'b1;
      r_opcode   <= rom_opcode;
      r_operand  <= rom_operand;
      r_instr_pc <= r_pc;
    end else if (instr_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign rom_addr      = r_pc;
  assign rom_enable    = (r_state == S_RUN);
  assign halted        = (r_state == S_HALTED);
  assign instr_valid   = r_valid;
  assign instr_opcode  = r_opcode;
  assign instr_operand = r_operand;
  assign instr_pc      = r_instr_pc;

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Program-counter and fetch stage that sits directly upstream of the 32-bit-word program ROM. It drives the ROM address and enable, captures the combinational opcode/operand halves into an instruction register, and presents them to the decode/execute stage over a valid/ready handshake. It supports control-flow redirects from execute, plus halt and start control.

## Interface
- DATA_WIDTH, 16: width of the PC, ROM address, opcode and operand.
- RESET_PC, 16'h0000: PC value after reset.
- HALT_OPCODE, 16'hFFFF: opcode recognised as self-halt (only with FETCH_HALT_DETECT_EN).

Ports:
- clk, input, 1: the single clock; all state is on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: level/pulse; IDLE or HALTED → RUN.
- halt_req, input, 1: stop fetching (RUN → HALTED).
- redirect_valid, input, 1: load PC from redirect_pc and flush the instruction register.
- redirect_pc, input, 16: redirect target.
- rom_addr, output, 16: ROM address; always equals PC.
- rom_enable, output, 1: high only in RUN.
- rom_opcode, input, 16: ROM upper half, combinational from rom_addr.
- rom_operand, input, 16: ROM lower half.
- instr_valid, output, 1: instruction register holds an instruction.
- instr_ready, input, 1: downstream accepts the instruction this cycle.
- instr_opcode, output, 16: captured opcode.
- instr_operand, output, 16: captured operand.
- instr_pc, output, 16: address the instruction came from.
- halted, output, 1: FSM in HALTED.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - HALTED.
- State transitions:
  - IDLE/HALTED + start → RUN.
  - RUN + halt_req → HALTED.
  - start is ignored in RUN.
- Fetch fires on an edge when state is RUN, halt_req=0, redirect_valid=0, and (instr_valid=0 or instr_ready=1). On a fetch:
  - instr_opcode/operand take rom_opcode/rom_operand.
  - instr_pc takes PC.
  - instr_valid goes to 1.
  - PC becomes PC+1, modulo 2^16: 16'hFFFF wraps to 16'h0000.
- When instr_valid=1, instr_ready=1 and no fetch fires, instr_valid goes to 0.
- While instr_valid=1 and instr_ready=0, instr_* hold stable and no fetch occurs.
- redirect_valid has the highest priority and is honoured in any state:
  - PC takes redirect_pc.
  - instr_valid goes to 0, even if instr_ready=0.
  - No fetch that cycle.
  - State is unchanged.
- halt_req with a valid instruction in the register: that instruction stays valid and drains normally. Only new fetches stop.
- Resume from HALTED continues at the current PC. PC is never reset by start.
- redirect_valid and halt_req together: both take effect (PC loaded, flush, → HALTED).
- rom_enable=0 outside RUN. Fetch never samples ROM data while rom_enable=0.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - state = IDLE.
  - PC = RESET_PC, so rom_addr = RESET_PC.
  - rom_enable = 0.
  - instr_valid = 0.
  - instr_opcode = instr_operand = instr_pc = 0.
  - halted = 0.
- Reset mid-operation: the above values are applied immediately, and any in-flight instruction is lost.
- start sampled at edge N: rom_enable is high after N. The first fetch is at edge N+1, so instr_valid is high after N+1.
- Throughput: one instruction per cycle while instr_ready stays high. Latency from PC to instr_valid is 1 cycle.
- Redirect sampled at edge N: rom_addr = redirect_pc after N. The first instruction from the target is valid after N+1.
- halt_req at edge N: halted=1 and rom_enable=0 after N.

## Configuration
- FETCH_HALT_DETECT_EN defined:
  - A fetch whose rom_opcode equals HALT_OPCODE is presented normally (instr_valid=1).
  - On the same edge the FSM enters HALTED.
  - PC is not incremented; it stays at the halt instruction's address.
- Not defined: HALT_OPCODE is an ordinary opcode. Only halt_req stops fetching.

## Test plan
- Reset, then start with the ROM holding 0x00010002, 0x00030004 at addresses 0 and 1, and instr_ready=1 → instr_pc 0 then 1 on consecutive cycles, with opcode/operand 0001/0002 then 0003/0004.
- Backpressure: instr_ready=0 for 3 cycles with instr_valid=1 → instr_* and rom_addr are stable for all 3 cycles. After ready rises, the next instruction follows 1 cycle later with no skip or duplicate.
- Redirect to 16'h0020 while instr_valid=1 and instr_ready=0 → instr_valid drops on the next edge, then the instruction with instr_pc=16'h0020 is valid one cycle after that.
- halt_req with an instruction pending → the pending instruction drains, halted=1, rom_enable=0, PC frozen. start then resumes at the same PC. Also check the wrap from PC 16'hFFFF to 16'h0000.
- With FETCH_HALT_DETECT_EN, the word 0xFFFF0000 at address 5 → instruction 5 is presented, halted=1, rom_addr=5. Without the macro, fetching continues to address 6.
- Assert rst_n=0 mid-stream → all outputs reach their reset values without waiting for a clock edge.
